special_float_rounder: RTL and testbench
========================================

SPECIAL_FLOAT_ROUNDER -- requirements
Module: special_float_rounder

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width (>=2).
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored fraction width (>=1).
REQ-003 SHALL have parameter ROUND_TO_NEAREST_TIES_TO_EVEN, default 1; 1 = round to nearest, ties to even; 0 = truncate.
REQ-004 SHALL have parameter ROUNDING_BITS, default MANTISSA_WIDTH+1, width of discarded-bits input (>=2).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  qualifies all data inputs this cycle.
REQ-009 a  input  1+EXPONENT_WIDTH+MANTISSA_WIDTH  operand to classify, packed {sign, exponent, fraction}.
REQ-010 non_rounded_exponent  input  EXPONENT_WIDTH  biased exponent before rounding.
REQ-011 non_rounded_mantissa  input  MANTISSA_WIDTH  fraction before rounding.
REQ-012 rounding_bits  input  ROUNDING_BITS  discarded low bits; MSB is the guard bit.
REQ-013 out_valid  output  1  registered copy of in_valid.
REQ-014 is_infinite, is_zero, is_signaling_nan, is_quiet_nan, is_subnormal  output  1 each  registered classification of a.
REQ-015 rounded_exponent  output  EXPONENT_WIDTH; rounded_mantissa  output  MANTISSA_WIDTH; overflow_flag  output  1.

Function
REQ-016 All outputs SHALL be registered with a latency of exactly 1 cycle; outputs SHALL update only on a clk edge where in_valid=1, and otherwise hold their values.
REQ-017 out_valid SHALL equal in_valid as sampled on the previous clk edge.
REQ-018 Classification: exp==0 and frac==0 -> is_zero; exp==0 and frac!=0 -> is_subnormal; exp all ones and frac==0 -> is_infinite; exp all ones, frac!=0, frac MSB=1 -> is_quiet_nan; exp all ones, frac!=0, frac MSB=0 -> is_signaling_nan.
REQ-019 At most one classification flag SHALL be 1; the sign bit SHALL be ignored.
REQ-020 Rounding, mode 1: guard = rounding_bits MSB; sticky = OR of the remaining bits; round up when guard AND (sticky OR LSB of non_rounded_mantissa).
REQ-021 Round up SHALL increment the mantissa; a carry out SHALL clear the mantissa and increment the exponent.
REQ-022 If the resulting exponent is all ones, outputs SHALL be that exponent with mantissa 0, and overflow_flag SHALL be 1.
REQ-023 An input exponent already all ones SHALL pass through unchanged with overflow_flag=0.
REQ-024 Mode 0 SHALL pass the exponent and mantissa through unchanged, with overflow_flag=0.
REQ-025 Classification and rounding SHALL be independent paths captured in the same cycle.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-027 A reset asserted mid-operation SHALL discard the in-flight result; the first valid output after release SHALL be one cycle after the first sampled in_valid=1.

Configuration
REQ-028 Macro SPECIAL_FLOAT_E4M3_EN: when defined and EXPONENT_WIDTH=4 and MANTISSA_WIDTH=3, is_infinite SHALL be constant 0, and only exp=1111, frac=111 SHALL be NaN, reported as is_quiet_nan; is_signaling_nan SHALL be 0; all other exp=1111 codes SHALL be normal numbers.
REQ-029 Without SPECIAL_FLOAT_E4M3_EN, or for any other widths, REQ-018 SHALL apply unchanged.

Verification
REQ-030 FP32 defaults: a=0x7F800000 / 0x7FC00000 / 0x7F800001 / 0x00000001 / 0x80000000 -> one cycle later, infinite / quiet_nan / signaling_nan / subnormal / zero.
REQ-031 exp=0x7F, mant=0x000001, rounding_bits=0x800000 -> mant=0x000002, exp=0x7F, overflow_flag=0; with mant=0x000000 -> mant=0x000000.
REQ-032 exp=0x7F, mant=0x000000, rounding_bits=0x800001 -> mant=0x000001; rounding_bits=0x7FFFFF -> mant=0x000000.
REQ-033 exp=0xFE, mant=0x7FFFFF, rounding_bits=0xC00000 -> exp=0xFF, mant=0, overflow_flag=1; same stimulus in mode 0 -> exp=0xFE, mant=0x7FFFFF, flag=0.
REQ-034 E4M3 build with SPECIAL_FLOAT_E4M3_EN: a=0x7F -> is_quiet_nan=1; a=0x78 -> all flags 0; without the macro, a=0x78 -> is_infinite=1.
REQ-035 Assert rst_n=0 between capture and the next edge -> outputs 0 immediately; hold in_valid=0 -> outputs stay unchanged.

Source files
------------

// File: rtl/special_float_rounder.sv
// Classifies a packed float operand and rounds a pre-rounded exp/mantissa pair.
// Ports: clk, rst_n, in_valid, a, non_rounded_*, rounding_bits -> flags, rounded_*, overflow_flag, out_valid. Option: SPECIAL_FLOAT_E4M3_EN.
module special_float_rounder #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUND_TO_NEAREST_TIES_TO_EVEN = 1,
  parameter int ROUNDING_BITS = MANTISSA_WIDTH + 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  a,
  input  logic [EXPONENT_WIDTH-1:0]               non_rounded_exponent,
  input  logic [MANTISSA_WIDTH-1:0]               non_rounded_mantissa,
  input  logic [ROUNDING_BITS-1:0]                rounding_bits,
  output logic                                    out_valid,
  output logic                                    is_infinite,
  output logic                                    is_zero,
  output logic                                    is_signaling_nan,
  output logic                                    is_quiet_nan,
  output logic                                    is_subnormal,
  output logic [EXPONENT_WIDTH-1:0]               rounded_exponent,
  output logic [MANTISSA_WIDTH-1:0]               rounded_mantissa,
  output logic                                    overflow_flag
);

  localparam int E = EXPONENT_WIDTH;
  localparam int M = MANTISSA_WIDTH;

`ifdef SPECIAL_FLOAT_E4M3_EN
  localparam bit E4M3 = (E == 4) && (M == 3);
`else
  localparam bit E4M3 = 1'b0;
`endif

  logic         unused_sign;
  logic [E-1:0] a_exp;
  logic [M-1:0] a_frac;

  assign {unused_sign, a_exp, a_frac} = a;

  logic exp_ones, exp_zero, frac_zero;
  logic frac_ones, frac_msb;

  assign exp_ones  = &a_exp;
  assign exp_zero  = ~|a_exp;
  assign frac_zero = ~|a_frac;
  assign frac_ones = &a_frac;
  assign frac_msb  = a_frac[M-1];

  logic c_inf, c_zero, c_snan, c_qnan, c_sub;

  always_comb begin
    c_inf  = 1'b0;
    c_snan = 1'b0;
    c_qnan = 1'b0;
    c_zero = exp_zero & frac_zero;
    c_sub  = exp_zero & ~frac_zero;
    if (E4M3) begin
      // only the all-ones code is NaN; no infinities
      c_qnan = exp_ones & frac_ones;
    end else begin
      c_inf  = exp_ones & frac_zero;
      c_qnan = exp_ones & ~frac_zero & frac_msb;
      c_snan = exp_ones & ~frac_zero & ~frac_msb;
    end
  end

  logic guard, sticky, round_up;
  logic [E+M-1:0] sum;

  assign guard    = rounding_bits[ROUNDING_BITS-1];
  assign sticky   = |rounding_bits[ROUNDING_BITS-2:0];
  assign round_up = guard & (sticky | non_rounded_mantissa[0]);

  // mantissa carry ripples straight into the exponent field
  assign sum = {non_rounded_exponent, non_rounded_mantissa}
             + {{(E+M-1){1'b0}}, round_up};

  logic [E-1:0] r_exp;
  logic [M-1:0] r_mant;
  logic         r_ovf;

  always_comb begin
    r_exp  = non_rounded_exponent;
    r_mant = non_rounded_mantissa;
    r_ovf  = 1'b0;
    if (ROUND_TO_NEAREST_TIES_TO_EVEN != 0 && !(&non_rounded_exponent)) begin
      r_exp  = sum[E+M-1:M];
      r_mant = sum[M-1:0];
      if (&sum[E+M-1:M]) begin
        r_mant = '0;
        r_ovf  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      is_infinite      <= 1'b0;
      is_zero          <= 1'b0;
      is_signaling_nan <= 1'b0;
      is_quiet_nan     <= 1'b0;
      is_subnormal     <= 1'b0;
      rounded_exponent <= '0;
      rounded_mantissa <= '0;
      overflow_flag    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        is_infinite      <= c_inf;
        is_zero          <= c_zero;
        is_signaling_nan <= c_snan;
        is_quiet_nan     <= c_qnan;
        is_subnormal     <= c_sub;
        rounded_exponent <= r_exp;
        rounded_mantissa <= r_mant;
        overflow_flag    <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_special_float_rounder.sv
// Directed-vector bench for special_float_rounder: FP32 round/truncate, E4M3 build.
// Checks classification, rounding, hold, and asynchronous reset behaviour.
module tb_special_float_rounder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [7:0]  ne = '0;
  logic [22:0] nm = '0;
  logic [23:0] rb = '0;

  logic ov1, inf1, zer1, sn1, qn1, sub1, of1;
  logic [7:0]  re1;
  logic [22:0] rm1;
  logic ov0, inf0, zer0, sn0, qn0, sub0, of0;
  logic [7:0]  re0;
  logic [22:0] rm0;

  logic       ve = 1'b0;
  logic [7:0] ae = '0;
  logic [3:0] ee = '0;
  logic [2:0] me = '0;
  logic [3:0] rbe = '0;
  logic ove, infe, zere, sne, qne, sube, ofe;
  logic [3:0] ree;
  logic [2:0] rme;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  special_float_rounder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .non_rounded_exponent(ne), .non_rounded_mantissa(nm),
    .rounding_bits(rb), .out_valid(ov1), .is_infinite(inf1),
    .is_zero(zer1), .is_signaling_nan(sn1), .is_quiet_nan(qn1),
    .is_subnormal(sub1), .rounded_exponent(re1),
    .rounded_mantissa(rm1), .overflow_flag(of1)
  );

  special_float_rounder #(.ROUND_TO_NEAREST_TIES_TO_EVEN(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .non_rounded_exponent(ne), .non_rounded_mantissa(nm),
    .rounding_bits(rb), .out_valid(ov0), .is_infinite(inf0),
    .is_zero(zer0), .is_signaling_nan(sn0), .is_quiet_nan(qn0),
    .is_subnormal(sub0), .rounded_exponent(re0),
    .rounded_mantissa(rm0), .overflow_flag(of0)
  );

  special_float_rounder #(
    .EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3)
  ) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(ve), .a(ae),
    .non_rounded_exponent(ee), .non_rounded_mantissa(me),
    .rounding_bits(rbe), .out_valid(ove), .is_infinite(infe),
    .is_zero(zere), .is_signaling_nan(sne), .is_quiet_nan(qne),
    .is_subnormal(sube), .rounded_exponent(ree),
    .rounded_mantissa(rme), .overflow_flag(ofe)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  e;
    logic [22:0] m;
    logic [23:0] rb;
    logic [4:0]  fl;
    logic [7:0]  xe;
    logic [22:0] xm;
    logic        xo;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, want);
    end
  endtask

  function automatic logic [4:0] fl1();
    return {inf1, zer1, sn1, qn1, sub1};
  endfunction

  task automatic apply(input vec_t x);
    @(negedge clk);
    in_valid = 1'b1;
    a  = x.a;
    ne = x.e;
    nm = x.m;
    rb = x.rb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_e(input logic [7:0] av, input logic [3:0] ev,
                         input logic [2:0] mv, input logic [3:0] rv);
    @(negedge clk);
    ve  = 1'b1;
    ae  = av;
    ee  = ev;
    me  = mv;
    rbe = rv;
    @(posedge clk);
    #1;
    ve = 1'b0;
  endtask

  logic [4:0] e78;

  initial begin
    // flags order: {inf, zero, snan, qnan, sub}
    v[0] = '{32'h7F800000, 8'h7F, 23'h000001, 24'h800000,
             5'b10000, 8'h7F, 23'h000002, 1'b0};
    v[1] = '{32'h7FC00000, 8'h7F, 23'h000000, 24'h800000,
             5'b00010, 8'h7F, 23'h000000, 1'b0};
    v[2] = '{32'h7F800001, 8'h7F, 23'h000000, 24'h800001,
             5'b00100, 8'h7F, 23'h000001, 1'b0};
    v[3] = '{32'h00000001, 8'h7F, 23'h000000, 24'h7FFFFF,
             5'b00001, 8'h7F, 23'h000000, 1'b0};
    v[4] = '{32'h80000000, 8'hFE, 23'h7FFFFF, 24'hC00000,
             5'b01000, 8'hFF, 23'h000000, 1'b1};
    v[5] = '{32'h3F800000, 8'hFF, 23'h123456, 24'hFFFFFF,
             5'b00000, 8'hFF, 23'h123456, 1'b0};
    v[6] = '{32'h00400000, 8'h7F, 23'h7FFFFF, 24'h800000,
             5'b00001, 8'h80, 23'h000000, 1'b0};
    v[7] = '{32'hFF800000, 8'h00, 23'h000003, 24'h800000,
             5'b10000, 8'h00, 23'h000004, 1'b0};
    v[8] = '{32'hFFFFFFFF, 8'h10, 23'h000002, 24'h400000,
             5'b00010, 8'h10, 23'h000002, 1'b0};

    #2;
    chk("reset_async", {ov1, fl1(), re1, rm1, of1}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_valid", {63'h0, ov1}, 64'h0);

    for (int i = 0; i < 9; i++) begin
      apply(v[i]);
      chk($sformatf("v%0d_valid", i), {63'h0, ov1}, 64'h1);
      chk($sformatf("v%0d_flags", i), {59'h0, fl1()}, {59'h0, v[i].fl});
      chk($sformatf("v%0d_round", i), {32'h0, re1, rm1, of1},
          {32'h0, v[i].xe, v[i].xm, v[i].xo});
      chk($sformatf("v%0d_trunc", i), {32'h0, re0, rm0, of0},
          {32'h0, v[i].e, v[i].m, 1'b0});
    end

    // idle cycles must hold the last captured result
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", {63'h0, ov1}, 64'h0);
    chk("hold_data", {27'h0, fl1(), re1, rm1, of1},
        {27'h0, v[8].fl, v[8].xe, v[8].xm, v[8].xo});

    // reset in the middle of a cycle clears without a clock edge
    apply(v[4]);
    chk("pre_rst_ovf", {63'h0, of1}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {ov1, fl1(), re1, rm1, of1}, 64'h0);
    chk("mid_rst_t", {ov0, inf0, zer0, sn0, qn0, sub0, re0, rm0, of0},
        64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {ov1, fl1(), re1, rm1, of1}, 64'h0);
    apply(v[0]);
    chk("post_rst_valid", {63'h0, ov1}, 64'h1);
    chk("post_rst_data", {27'h0, fl1(), re1, rm1, of1},
        {27'h0, v[0].fl, v[0].xe, v[0].xm, v[0].xo});

`ifdef SPECIAL_FLOAT_E4M3_EN
    e78 = 5'b00000;
`else
    e78 = 5'b10000;
`endif
    apply_e(8'h78, 4'hE, 3'h7, 4'h8);
    chk("e4m3_78_flags", {59'h0, infe, zere, sne, qne, sube},
        {59'h0, e78});
    chk("e4m3_ovf", {56'h0, ree, rme, ofe}, {56'h0, 4'hF, 3'h0, 1'b1});
    apply_e(8'h7F, 4'h3, 3'h2, 4'h7);
    chk("e4m3_7f_flags", {59'h0, infe, zere, sne, qne, sube},
        64'b00010);
    chk("e4m3_noround", {56'h0, ree, rme, ofe}, {56'h0, 4'h3, 3'h2, 1'b0});
    apply_e(8'h01, 4'h2, 3'h1, 4'hC);
    chk("e4m3_sub", {59'h0, infe, zere, sne, qne, sube}, 64'b00001);
    chk("e4m3_round", {56'h0, ree, rme, ofe}, {56'h0, 4'h2, 3'h2, 1'b0});
    chk("e4m3_valid", {63'h0, ove}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
